gf180mcu_fd_sc_mcu7t5v0__rrarb4_func: RTL and testbench
=======================================================

GF180MCU_FD_SC_MCU7T5V0__RRARB4_FUNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__rrarb4_func

Interface
REQ-001 Parameter MAXHOLD, default 0, maximum grant tenure in cycles while another requester waits; 0 means unlimited; legal range 0..255.
REQ-002 CLK  input  1  sole clock, rising-edge active.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 A1, A2, A3, A4  input  1 each  request lines, same four sources whose OR forms the shared request.
REQ-005 G1, G2, G3, G4  output  1 each  registered grants, one-hot or all-zero.
REQ-006 Z  output  1  registered busy flag, equal to OR of G1..G4.
REQ-007 VDD, VSS  inout  1 each  supply pins, no functional effect.

Function
REQ-008 State machine SHALL have two states: IDLE (no grant) and GRANT (exactly one Gn high).
REQ-009 Grant latency SHALL be one cycle: request sampled at edge k, grant visible after edge k.
REQ-010 Winner SHALL be the first asserted An at or after the rotating pointer P, scanning 1->2->3->4->1.
REQ-011 P SHALL advance to holder+1 (4 wraps to 1) whenever a grant is released or revoked.
REQ-012 In IDLE with all An low, SHALL remain IDLE with G=0 and Z=0.
REQ-013 In GRANT, holder SHALL keep its grant while its An stays high and tenure is not exhausted.
REQ-014 Holder dropping An while others request SHALL hand over directly to the next winner at the same edge, with no idle bubble.
REQ-015 Holder dropping An with no other request SHALL return to IDLE, with G=0 after that edge.
REQ-016 Tenure counter SHALL clear to 0 on every new grant, increment each cycle in GRANT, and saturate at MAXHOLD.
REQ-017 MAXHOLD>0, counter==MAXHOLD-1 and another An high SHALL revoke the holder at the next edge and grant the next winner, excluding the holder.
REQ-018 MAXHOLD>0 with no other requester SHALL let the holder keep its grant past MAXHOLD.
REQ-019 Z SHALL never differ from OR(G1..G4) in any cycle.

Reset
REQ-020 RST high at an edge SHALL force G1..G4=0, Z=0, state IDLE, P=1, and counter=0.
REQ-021 RST SHALL dominate all requests at the same edge, including mid-grant; arbitration SHALL resume on the first edge with RST low.

Configuration
REQ-022 Macro GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN defined SHALL add input port LOCK (1 bit, after A4).
REQ-023 With the macro defined and LOCK high, the holder SHALL keep its grant regardless of its An and of MAXHOLD, the counter SHALL freeze, and IDLE SHALL be unaffected.
REQ-024 With the macro undefined, no LOCK port SHALL exist and behaviour SHALL be exactly REQ-008..REQ-019.

Structure
REQ-025 Shared package gf180mcu_fd_sc_mcu7t5v0__arb_pkg SHALL hold the state enum (IDLE, GRANT), the 2-bit requester index type, and the MAXHOLD upper-bound constant 255.
REQ-026 One combinational sub-module, gf180mcu_fd_sc_mcu7t5v0__rrpick4 (inputs: 4-bit request vector, pointer, exclude mask; outputs: one-hot winner, valid), SHALL implement REQ-010/REQ-017 selection.
REQ-027 All state (grant vector, P, counter, state) SHALL reside in the top module.

Verification
REQ-028 Reset then A1..A4=1111, MAXHOLD=0 -> G=0001 one edge later; holder drops A1 -> G=0010 next edge; Z=1 throughout.
REQ-029 MAXHOLD=3, A1 and A3 held high -> G1 for 3 cycles, then G3 for 3 cycles, then G1 again, repeating.
REQ-030 MAXHOLD=3, only A2 high for 10 cycles -> G2 held for all 10 cycles, no revocation.
REQ-031 G3 held, RST pulsed one cycle with all An=1111 -> G=0000, Z=0 that edge; next edge G=0001 (P reset to 1).
REQ-032 Holder A4 drops with A1..A3 low -> G=0000, Z=0 next edge; then A2 and A3 rise together -> G=0010 (P=1 after wrap, first hit is 2).
REQ-033 LOCK_EN build, G2 held, LOCK=1, A2 dropped, A1 high -> G2 retained; LOCK=0 -> G=0001 next edge.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_pkg.sv
// Shared types for the 4-way round-robin arbiter family: FSM states,
// requester index and the upper bound for the grant-tenure parameter.
package gf180mcu_fd_sc_mcu7t5v0__arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  typedef logic [1:0] req_idx_t;

  localparam int unsigned MAXHOLD_LIMIT = 255;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrpick4.sv
// Combinational round-robin picker: first request at or after ptr
// (scanning upward with wrap) that is not masked by excl.
module gf180mcu_fd_sc_mcu7t5v0__rrpick4
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   ptr,
  input  logic [3:0] excl,
  output logic [3:0] win,
  output logic       valid
);

  req_idx_t idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + req_idx_t'(i);
      if (!valid && req[idx] && !excl[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_func.sv
// 4-input round-robin arbiter with optional grant-tenure limit (MAXHOLD, 0..255,
// 0 = unlimited). Optional LOCK input under GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN.
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_func
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
#(
  parameter int unsigned MAXHOLD = 0
)
(
  input  logic CLK,
  input  logic RST,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
  input  logic LOCK,
`endif
  output logic G1,
  output logic G2,
  output logic G3,
  output logic G4,
  output logic Z,
  inout  wire  VDD,
  inout  wire  VSS
);

  localparam logic [7:0] HOLD = 8'(MAXHOLD);

  arb_state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  req_idx_t   ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] req;
  req_idx_t   holder;
  logic       holder_req, others, exhausted, hold_lock;
  req_idx_t   pick_ptr;
  logic [3:0] pick_excl, pick_win;
  logic       pick_valid;
  logic       unused_supply;

  assign req           = {A4, A3, A2, A1};
  assign unused_supply = VDD ^ VSS;

`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
  assign hold_lock = LOCK;
`else
  assign hold_lock = 1'b0;
`endif

  always_comb begin
    holder = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (gnt_q[i]) holder = req_idx_t'(i);
  end

  assign holder_req = |(req & gnt_q);
  assign others     = |(req & ~gnt_q);
  // ">=" rather than "==": the counter saturates at HOLD while the holder is
  // alone, so a late-arriving requester must still see the tenure as spent.
  assign exhausted  = (HOLD != 8'd0) && (cnt_q >= HOLD - 8'd1) && others;

  // While granted, the search starts just past the holder and skips it.
  assign pick_ptr  = (state_q == GRANT) ? holder + 2'd1 : ptr_q;
  assign pick_excl = (state_q == GRANT) ? gnt_q : '0;

  gf180mcu_fd_sc_mcu7t5v0__rrpick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!hold_lock) begin
          if (holder_req && !exhausted) begin
            if (cnt_q != HOLD) cnt_d = cnt_q + 8'd1;
          end else begin
            ptr_d   = pick_ptr;
            gnt_d   = pick_win;
            cnt_d   = '0;
            state_d = pick_valid ? GRANT : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {G4, G3, G2, G1} = gnt_q;
  assign Z                = |gnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_func.sv
// Bench for the round-robin arbiter: MAXHOLD=0 and MAXHOLD=3 instances on shared
// inputs, checked against a behavioural model plus directed scenarios.
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_func;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = '0;
  logic       lock = 1'b0;
  wire        vdd, vss;
  logic [3:0] g0, g3;
  logic       z0, z3;

  int total = 0;
  int bad   = 0;

  int mh[2]     = '{0, 3};
  int m_hold[2] = '{-1, -1};
  int m_ptr[2]  = '{0, 0};
  int m_ten[2]  = '{0, 0};

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rrarb4_func #(.MAXHOLD(0)) dut0 (
    .CLK(clk), .RST(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
    .LOCK(lock),
`endif
    .G1(g0[0]), .G2(g0[1]), .G3(g0[2]), .G4(g0[3]), .Z(z0),
    .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__rrarb4_func #(.MAXHOLD(3)) dut3 (
    .CLK(clk), .RST(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
    .LOCK(lock),
`endif
    .G1(g3[0]), .G2(g3[1]), .G3(g3[2]), .G4(g3[3]), .Z(z3),
    .VDD(vdd), .VSS(vss)
  );

  function automatic int first_from(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (j != skip && r[j]) return j;
    end
    return -1;
  endfunction

  // Model: who holds the grant, where the search starts, and how long the holder has held.
  task automatic model_edge(input int d, input logic [3:0] r, input logic rs, input logic lk);
    int h;
    bit oth;
    if (rs) begin
      m_hold[d] = -1; m_ptr[d] = 0; m_ten[d] = 0;
    end else if (m_hold[d] < 0) begin
      m_hold[d] = first_from(r, m_ptr[d], -1);
      m_ten[d]  = 0;
    end else if (!lk) begin
      h   = m_hold[d];
      oth = (r & ~(4'b0001 << h)) != 4'b0000;
      if (r[h] && !(mh[d] > 0 && m_ten[d] >= mh[d] - 1 && oth)) begin
        m_ten[d]++;
      end else begin
        m_ptr[d]  = (h + 1) % 4;
        m_hold[d] = first_from(r, m_ptr[d], h);
        m_ten[d]  = 0;
      end
    end
  endtask

  task automatic expect_v(input logic [3:0] obs, input logic [3:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] e0, e3;
    e0 = (m_hold[0] < 0) ? 4'b0000 : (4'b0001 << m_hold[0]);
    e3 = (m_hold[1] < 0) ? 4'b0000 : (4'b0001 << m_hold[1]);
    expect_v(g0, e0, {tag, "_g0"});
    expect_v({3'b000, z0}, {3'b000, |e0}, {tag, "_z0"});
    expect_v(g3, e3, {tag, "_g3"});
    expect_v({3'b000, z3}, {3'b000, |e3}, {tag, "_z3"});
  endtask

  task automatic step(input logic [3:0] r, input logic rs, input string tag);
    a   = r;
    rst = rs;
    @(posedge clk);
    model_edge(0, r, rs, lock);
    model_edge(1, r, rs, lock);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       rs;

    step(4'b1111, 1'b1, "reset");
    expect_v(g0, 4'b0000, "reset_g");
    expect_v({3'b000, z0}, 4'b0000, "reset_z");

    // all request: A1 wins, then handover to A2 without bubble
    step(4'b1111, 1'b0, "r028a");
    expect_v(g0, 4'b0001, "r028a_g");
    expect_v({3'b000, z0}, 4'b0001, "r028a_z");
    step(4'b1110, 1'b0, "r028b");
    expect_v(g0, 4'b0010, "r028b_g");
    expect_v({3'b000, z0}, 4'b0001, "r028b_z");

    // tenure limit 3 alternates A1 / A3
    step(4'b0101, 1'b1, "r029rst");
    for (int i = 0; i < 12; i++) begin
      step(4'b0101, 1'b0, "r029");
      expect_v(g3, ((i / 3) % 2 == 0) ? 4'b0001 : 4'b0100, "r029_g3");
    end

    // lone requester is never revoked
    step(4'b0010, 1'b1, "r030rst");
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, 1'b0, "r030");
      expect_v(g3, 4'b0010, "r030_g3");
    end

    // reset mid-grant
    step(4'b0100, 1'b1, "r031rst");
    step(4'b0100, 1'b0, "r031a");
    expect_v(g0, 4'b0100, "r031a_g");
    step(4'b1111, 1'b1, "r031b");
    expect_v(g0, 4'b0000, "r031b_g");
    expect_v({3'b000, z0}, 4'b0000, "r031b_z");
    step(4'b1111, 1'b0, "r031c");
    expect_v(g0, 4'b0001, "r031c_g");

    // release from A4 wraps pointer to A1
    step(4'b1000, 1'b1, "r032rst");
    step(4'b1000, 1'b0, "r032a");
    expect_v(g0, 4'b1000, "r032a_g");
    step(4'b0000, 1'b0, "r032b");
    expect_v(g0, 4'b0000, "r032b_g");
    expect_v({3'b000, z0}, 4'b0000, "r032b_z");
    step(4'b0110, 1'b0, "r032c");
    expect_v(g0, 4'b0010, "r032c_g");

`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
    step(4'b0010, 1'b1, "r033rst");
    step(4'b0010, 1'b0, "r033a");
    expect_v(g0, 4'b0010, "r033a_g");
    lock = 1'b1;
    step(4'b0001, 1'b0, "r033b");
    expect_v(g0, 4'b0010, "r033b_g");
    lock = 1'b0;
    step(4'b0001, 1'b0, "r033c");
    expect_v(g0, 4'b0001, "r033c_g");
`endif

    // random traffic; requests often persist to exercise tenure limits
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 63) == 0);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB4_LOCK_EN
      lock = ($urandom_range(0, 7) == 0);
`endif
      step(r, rs, "rand");
    end
    lock = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
